// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID decode plus EX/MEM/WB control pipeline with load-use and multiply stalls.
// Define CTRL_MUL_EN to enable multiply detection and the MUL_CYCLES busy stall.
module pipe_ctrl_unit #(
  parameter int unsigned ALUOP_W    = 2,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  input  logic [6:0]         opcode_i,
  input  logic [6:0]         funct7_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic [4:0]         rd_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               Branch_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               ALUSrc_o,
  output logic               ex_mul_o,
  output logic [4:0]         ex_rd_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               RegWrite_o,
  output logic               MemtoReg_o,
  output logic [4:0]         wb_rd_o
);

  typedef enum logic [6:0] {
    OpR     = 7'b0110011,
    OpIAlu  = 7'b0010011,
    OpLoad  = 7'b0000011,
    OpStore = 7'b0100011,
    OpBeq   = 7'b1100011
  } opcodeE;

  typedef struct packed {
    logic               regWrite;
    logic               memtoReg;
    logic               memRead;
    logic               memWrite;
    logic               aluSrc;
    logic [ALUOP_W-1:0] aluOp;
    logic [4:0]         rd;
  } exCtrlT;

  typedef struct packed {
    logic       regWrite;
    logic       memtoReg;
    logic       memRead;
    logic       memWrite;
    logic [4:0] rd;
  } memCtrlT;

  typedef struct packed {
    logic       regWrite;
    logic       memtoReg;
    logic [4:0] rd;
  } wbCtrlT;

  exCtrlT  dec;
  exCtrlT  exQ;
  memCtrlT memQ;
  wbCtrlT  wbQ;
  logic    decBranch;
  logic    useRs1;
  logic    useRs2;
  logic    loadUse;
  logic    mulBusy;
  logic    takeId;

  always_comb begin
    dec       = '0;
    decBranch = 1'b0;
    useRs1    = 1'b0;
    useRs2    = 1'b0;
    if (id_valid_i) begin
      case (opcode_i)
        OpR: begin
          dec.regWrite = 1'b1;
          dec.aluOp    = ALUOP_W'(2'b10);
          dec.rd       = rd_i;
          useRs1       = 1'b1;
          useRs2       = 1'b1;
        end
        OpIAlu: begin
          dec.regWrite = 1'b1;
          dec.aluSrc   = 1'b1;
          dec.aluOp    = ALUOP_W'(2'b11);
          dec.rd       = rd_i;
          useRs1       = 1'b1;
        end
        OpLoad: begin
          dec.regWrite = 1'b1;
          dec.memRead  = 1'b1;
          dec.memtoReg = 1'b1;
          dec.aluSrc   = 1'b1;
          dec.rd       = rd_i;
          useRs1       = 1'b1;
        end
        OpStore: begin
          dec.memWrite = 1'b1;
          dec.aluSrc   = 1'b1;
          dec.rd       = rd_i;
          useRs1       = 1'b1;
          useRs2       = 1'b1;
        end
        OpBeq: begin
          decBranch = 1'b1;
          dec.aluOp = ALUOP_W'(2'b01);
          dec.rd    = rd_i;
          useRs1    = 1'b1;
          useRs2    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Load-use is not evaluated while a multiply occupies EX.
  assign loadUse = !mulBusy && exQ.memRead && (exQ.rd != '0) &&
                   ((useRs1 && (rs1_i == exQ.rd)) || (useRs2 && (rs2_i == exQ.rd)));
  assign takeId  = !loadUse && !flush_i;
  assign stall_o = mulBusy || loadUse;
  // Qualified with reset so every output is low while reset is asserted.
  assign Branch_o = rst_i && decBranch && !stall_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      exQ  <= '0;
      memQ <= '0;
      wbQ  <= '0;
    end else begin
      wbQ <= '{regWrite: memQ.regWrite, memtoReg: memQ.memtoReg, rd: memQ.rd};
      if (mulBusy) begin
        memQ <= '0;
      end else begin
        memQ <= '{regWrite: exQ.regWrite, memtoReg: exQ.memtoReg,
                  memRead: exQ.memRead, memWrite: exQ.memWrite, rd: exQ.rd};
        exQ  <= takeId ? dec : '0;
      end
    end
  end

`ifdef CTRL_MUL_EN
  logic [3:0] busyCnt;
  logic       exMul;
  logic       decMul;

  assign decMul = id_valid_i && (opcode_i == OpR) && (funct7_i == 7'b0000001);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busyCnt <= '0;
      exMul   <= 1'b0;
    end else if (mulBusy) begin
      busyCnt <= busyCnt - 4'd1;
    end else begin
      exMul   <= decMul && takeId;
      busyCnt <= (decMul && takeId) ? 4'(MUL_CYCLES - 1) : '0;
    end
  end

  assign mulBusy  = (busyCnt != '0);
  assign ex_mul_o = exMul;
`else
  logic unusedCfg;
  assign unusedCfg = ^{funct7_i, 4'(MUL_CYCLES)};
  assign mulBusy   = 1'b0;
  assign ex_mul_o  = 1'b0;
`endif

  assign ALUOp_o    = exQ.aluOp;
  assign ALUSrc_o   = exQ.aluSrc;
  assign ex_rd_o    = exQ.rd;
  assign MemRead_o  = memQ.memRead;
  assign MemWrite_o = memQ.memWrite;
  assign RegWrite_o = wbQ.regWrite;
  assign MemtoReg_o = wbQ.memtoReg;
  assign wb_rd_o    = wbQ.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit: directed hazard cases plus random stream against a stage-history model.
module tb_pipe_ctrl_unit;
  localparam int unsigned ALUOP_W    = 2;
  localparam int unsigned MUL_CYCLES = 3;
`ifdef CTRL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam bit [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                       OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_BAD = 7'b1111111;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic               id_valid_i = 1'b0;
  logic [6:0]         opcode_i = '0;
  logic [6:0]         funct7_i = '0;
  logic [4:0]         rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic               flush_i = 1'b0;
  logic               stall_o, Branch_o, ALUSrc_o, ex_mul_o;
  logic [ALUOP_W-1:0] ALUOp_o;
  logic [4:0]         ex_rd_o, wb_rd_o;
  logic               MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o;

  pipe_ctrl_unit #(.ALUOP_W(ALUOP_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .opcode_i(opcode_i),
    .funct7_i(funct7_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .Branch_o(Branch_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
    .ex_mul_o(ex_mul_o), .ex_rd_o(ex_rd_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .wb_rd_o(wb_rd_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: one instruction record per stage, MEM/WB taken from a history queue.
  typedef struct {
    bit regWrite, memRead, memWrite, memtoReg, aluSrc, isMul;
    int aluOp;
    int rd;
  } instT;

  instT bubble = '{default: 0};
  instT exB;
  int   exLeft;
  instT memHist[$];
  bit   lastStall;

  int nAsserts = 0;
  int nFail    = 0;

  task automatic checkVal(string tag, logic [31:0] got, logic [31:0] exp);
    nAsserts++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instT decodeRef(bit v, bit [6:0] op, bit [6:0] f7, int rd);
    instT b = '{default: 0};
    if (!v) return b;
    case (op)
      OP_R:   begin b.regWrite = 1; b.aluOp = 2; b.rd = rd; b.isMul = MUL_EN && (f7 == 7'd1); end
      OP_I:   begin b.regWrite = 1; b.aluSrc = 1; b.aluOp = 3; b.rd = rd; end
      OP_LW:  begin b.regWrite = 1; b.memRead = 1; b.memtoReg = 1; b.aluSrc = 1; b.rd = rd; end
      OP_SW:  begin b.memWrite = 1; b.aluSrc = 1; b.rd = rd; end
      OP_BEQ: begin b.aluOp = 1; b.rd = rd; end
      default: ;
    endcase
    return b;
  endfunction

  function automatic bit readsReg(bit v, bit [6:0] op, int r1, int r2, int r);
    if (!v || r == 0) return 0;
    case (op)
      OP_R, OP_SW, OP_BEQ: return (r1 == r) || (r2 == r);
      OP_I, OP_LW:         return r1 == r;
      default:             return 0;
    endcase
  endfunction

  task automatic modelReset();
    exB       = bubble;
    exLeft    = 0;
    lastStall = 0;
    memHist   = {bubble, bubble};
  endtask

  task automatic checkZeros(string tag);
    checkVal({tag, ".stall"}, stall_o, 0);
    checkVal({tag, ".Branch"}, Branch_o, 0);
    checkVal({tag, ".ALUOp"}, ALUOp_o, 0);
    checkVal({tag, ".ALUSrc"}, ALUSrc_o, 0);
    checkVal({tag, ".exMul"}, ex_mul_o, 0);
    checkVal({tag, ".exRd"}, ex_rd_o, 0);
    checkVal({tag, ".MemRead"}, MemRead_o, 0);
    checkVal({tag, ".MemWrite"}, MemWrite_o, 0);
    checkVal({tag, ".RegWrite"}, RegWrite_o, 0);
    checkVal({tag, ".MemtoReg"}, MemtoReg_o, 0);
    checkVal({tag, ".wbRd"}, wb_rd_o, 0);
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic cycleStep();
    bit   expStall, expBr;
    instT mem, wb, dec;
    @(negedge clk_i);
    expStall = (exLeft > 0) ||
               (exB.memRead && readsReg(id_valid_i, opcode_i, rs1_i, rs2_i, exB.rd));
    expBr    = id_valid_i && (opcode_i == OP_BEQ) && !expStall;
    mem = memHist[0];
    wb  = memHist[1];
    checkVal("stall", stall_o, expStall);
    checkVal("Branch", Branch_o, expBr);
    checkVal("ALUOp", ALUOp_o, exB.aluOp);
    checkVal("ALUSrc", ALUSrc_o, exB.aluSrc);
    checkVal("exMul", ex_mul_o, exB.isMul);
    checkVal("exRd", ex_rd_o, exB.rd);
    checkVal("MemRead", MemRead_o, mem.memRead);
    checkVal("MemWrite", MemWrite_o, mem.memWrite);
    checkVal("RegWrite", RegWrite_o, wb.regWrite);
    checkVal("MemtoReg", MemtoReg_o, wb.memtoReg);
    checkVal("wbRd", wb_rd_o, wb.rd);

    dec = decodeRef(id_valid_i, opcode_i, funct7_i, rd_i);
    if (exLeft > 0) begin
      memHist.push_front(bubble);
      exLeft--;
    end else begin
      memHist.push_front(exB);
      if (expStall || flush_i) exB = bubble;
      else begin
        exB    = dec;
        exLeft = dec.isMul ? int'(MUL_CYCLES) - 1 : 0;
      end
    end
    void'(memHist.pop_back());
    lastStall = expStall;
    @(posedge clk_i);
    #1;
  endtask

  // Present an instruction and keep it in ID until it is accepted; flush only on the first cycle.
  task automatic issue(bit v, bit [6:0] op, bit [6:0] f7, bit [4:0] r1, bit [4:0] r2,
                       bit [4:0] rd, bit fl);
    id_valid_i = v; opcode_i = op; funct7_i = f7;
    rs1_i = r1; rs2_i = r2; rd_i = rd; flush_i = fl;
    cycleStep();
    flush_i = 1'b0;
    for (int n = 0; n < 20 && lastStall; n++) cycleStep();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) issue(0, OP_R, 0, 0, 0, 0, 0);
  endtask

  initial begin
    modelReset();
    #3;
    checkZeros("resetInit");
    @(posedge clk_i);
    #3 rst_i = 1'b1;

    issue(1, OP_R, 0, 1, 2, 3, 0);          // ADD x3,x1,x2
    idle(4);
    issue(1, OP_LW, 0, 1, 0, 5, 0);         // LW x5
    issue(1, OP_R, 0, 5, 1, 6, 0);          // ADD x6,x5,x1 -> load-use
    idle(4);
    issue(1, OP_LW, 0, 1, 0, 5, 0);
    issue(1, OP_SW, 0, 2, 5, 9, 0);         // SW rs2=x5 -> load-use
    idle(4);
    issue(1, OP_LW, 0, 1, 0, 0, 0);         // LW x0
    issue(1, OP_R, 0, 0, 0, 1, 0);          // ADD x1,x0,x0 -> no stall
    idle(4);
    issue(1, OP_LW, 0, 1, 0, 5, 0);
    issue(1, OP_I, 0, 1, 5, 7, 0);          // ADDI, rs2 field unused -> no stall
    idle(4);
    issue(1, OP_R, 7'd1, 1, 2, 7, 0);       // MUL x7
    issue(1, OP_R, 0, 7, 1, 8, 0);          // ADD behind multiply
    idle(5);
    issue(1, OP_R, 7'd1, 1, 2, 7, 0);
    issue(1, OP_R, 0, 3, 4, 9, 1);          // flush while multiply busy
    idle(5);
    issue(1, OP_BEQ, 0, 1, 2, 4, 0);
    issue(1, OP_R, 0, 1, 2, 10, 1);         // flushed after taken branch
    idle(4);
    issue(1, OP_BAD, 0, 1, 2, 11, 0);
    issue(0, OP_LW, 0, 1, 2, 12, 0);
    idle(4);

    // Reset asserted between edges with a multiply in flight and a branch in ID.
    issue(1, OP_LW, 0, 1, 0, 5, 0);
    id_valid_i = 1; opcode_i = OP_R; funct7_i = 7'd1; rs1_i = 1; rs2_i = 2; rd_i = 13;
    cycleStep();
    opcode_i = OP_BEQ; funct7_i = 0;
    #2 rst_i = 1'b0;
    #1;
    checkZeros("resetMid");
    modelReset();
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    issue(1, OP_R, 0, 1, 2, 14, 0);
    idle(4);

    for (int i = 0; i < 500; i++) begin
      if (!lastStall) begin
        id_valid_i = ($urandom_range(0, 9) != 0);
        case ($urandom_range(0, 6))
          0: opcode_i = OP_R;
          1: opcode_i = OP_I;
          2: opcode_i = OP_LW;
          3: opcode_i = OP_SW;
          4: opcode_i = OP_BEQ;
          5: opcode_i = OP_BAD;
          default: opcode_i = 7'($urandom);
        endcase
        funct7_i = $urandom_range(0, 1) ? 7'd1 : 7'($urandom);
        rs1_i    = 5'($urandom_range(0, 3));
        rs2_i    = 5'($urandom_range(0, 3));
        rd_i     = 5'($urandom_range(0, 3));
      end
      flush_i = ($urandom_range(0, 6) == 0);
      cycleStep();
    end
    flush_i = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
